// File: rtl/wptr_handler_lvl_if.sv
// rtl/wptr_handler_lvl_if.sv - write-side pointer manager signal bundle
// Purpose: groups the write-domain request/flag signals of wptr_handler_lvl.
// Ports (signals):
//   w_en, g_rptr_async, af_level, ovf_clr        : driven by the user side (master)
//   b_wptr, g_wptr, waddr, full, almost_full,
//   wlevel, overflow                             : driven by the pointer manager (slave)
interface wptr_handler_lvl_if #(
  parameter int ADDR_WIDTH = 3
);
  localparam int PW = ADDR_WIDTH + 1;

  logic                  w_en;
  logic [PW-1:0]         g_rptr_async;
  logic [PW-1:0]         af_level;
  logic                  ovf_clr;
  logic [PW-1:0]         b_wptr;
  logic [PW-1:0]         g_wptr;
  logic [ADDR_WIDTH-1:0] waddr;
  logic                  full;
  logic                  almost_full;
  logic [PW-1:0]         wlevel;
  logic                  overflow;

  modport master (
    output w_en, g_rptr_async, af_level, ovf_clr,
    input  b_wptr, g_wptr, waddr, full, almost_full, wlevel, overflow
  );

  modport slave (
    input  w_en, g_rptr_async, af_level, ovf_clr,
    output b_wptr, g_wptr, waddr, full, almost_full, wlevel, overflow
  );
endinterface

// File: rtl/wptr_handler_lvl.sv
// rtl/wptr_handler_lvl.sv - async FIFO write pointer manager with level and flags
// Purpose: keeps binary/Gray write pointers, synchronises the read Gray pointer
//   into wclk, and produces full, almost_full, fill level and sticky overflow.
// Ports:
//   wclk : write-domain clock (rising edge)
//   wrst : asynchronous active-high reset
//   bus  : wptr_handler_lvl_if.slave (w_en, g_rptr_async, af_level, ovf_clr in;
//          b_wptr, g_wptr, waddr, full, almost_full, wlevel, overflow out)
module wptr_handler_lvl #(
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2
) (
  input logic              wclk,
  input logic              wrst,
  wptr_handler_lvl_if.slave bus
);
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  // Inverting the two MSBs of the read Gray pointer gives the Gray value the
  // write pointer has when exactly DEPTH words are outstanding.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

  logic [SYNC_STAGES-1:0][PW-1:0] sync_q, sync_d;
  logic [PW-1:0] b_wptr_q, b_wptr_d;
  logic [PW-1:0] g_wptr_q, g_wptr_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          full_q, full_d;
  logic          almost_full_q, almost_full_d;
  logic          overflow_q, overflow_d;

  logic [PW-1:0] g_rptr_sync;
  logic [PW-1:0] rptr_bin;
  logic          push;

  assign g_rptr_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = bus.g_rptr_async;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    rptr_bin = '0;
    for (int i = 0; i < PW; i++) begin
      rptr_bin[i] = ^(g_rptr_sync >> i);
    end

    push          = bus.w_en & ~full_q;
    b_wptr_d      = b_wptr_q + {{(PW-1){1'b0}}, push};
    g_wptr_d      = (b_wptr_d >> 1) ^ b_wptr_d;
    wlevel_d      = b_wptr_d - rptr_bin;
    full_d        = (g_wptr_d == (g_rptr_sync ^ FULL_MASK));
    almost_full_d = (wlevel_d >= bus.af_level);
    // A write attempt while full sets the flag even if clear is asserted.
    overflow_d    = (overflow_q & ~bus.ovf_clr) | (bus.w_en & full_q);
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      sync_q        <= '0;
      b_wptr_q      <= '0;
      g_wptr_q      <= '0;
      wlevel_q      <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      b_wptr_q      <= b_wptr_d;
      g_wptr_q      <= g_wptr_d;
      wlevel_q      <= wlevel_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  assign bus.b_wptr      = b_wptr_q;
  assign bus.g_wptr      = g_wptr_q;
  assign bus.waddr       = b_wptr_q[ADDR_WIDTH-1:0];
  assign bus.full        = full_q;
  assign bus.almost_full = almost_full_q;
  assign bus.wlevel      = wlevel_q;
  assign bus.overflow    = overflow_q;
endmodule
